// File: rtl/serial_sub_pkg.sv
// Shared constants, FSM state type and sizing helper for the nibble-serial subtractor.
package serial_sub_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int nibbles(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/nibble_subtractor.sv
// Combinational 4-bit ripple-borrow slice: o_d = i_x - i_y - i_bi, o_bo = borrow-out.
module nibble_subtractor
  import serial_sub_pkg::*;
(
  input  logic [NIBBLE-1:0] i_x,
  input  logic [NIBBLE-1:0] i_y,
  input  logic              i_bi,
  output logic [NIBBLE-1:0] o_d,
  output logic              o_bo
);

  logic [NIBBLE:0] w_borrow;

  assign w_borrow[0] = i_bi;

  for (genvar g = 0; g < NIBBLE; g++) begin : g_bit
    assign o_d[g]         = i_x[g] ^ i_y[g] ^ w_borrow[g];
    assign w_borrow[g+1]  = (~i_x[g] & i_y[g]) | (~i_x[g] & w_borrow[g]) | (i_y[g] & w_borrow[g]);
  end

  assign o_bo = w_borrow[NIBBLE];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - bin, one nibble per clock through a shared 4-bit borrow slice.
// Define SUB_FLAGS_EN to add the registered o_zero / o_ovf result flags.
module nibble_serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_ovf
`endif
);

  localparam int N     = nibbles(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic [NIBBLE-1:0] w_d;
  logic              w_bo;
  logic [WIDTH-1:0]  w_diff_next;

  nibble_subtractor u_slice (
    .i_x  (r_a[r_idx*NIBBLE +: NIBBLE]),
    .i_y  (r_b[r_idx*NIBBLE +: NIBBLE]),
    .i_bi (r_borrow),
    .o_d  (w_d),
    .o_bo (w_bo)
  );

  // NOTE: every always_comb output gets a full default first so a missed branch cannot infer a latch.
  always_comb begin
    w_diff_next                         = r_diff;
    w_diff_next[r_idx*NIBBLE +: NIBBLE] = w_d;
  end

`ifdef SUB_FLAGS_EN
  logic r_zero;
  logic r_ovf;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SUB_FLAGS_EN
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bin;
            r_idx    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff   <= w_diff_next;
          r_borrow <= w_bo;
          if (r_idx == IDX_LAST) begin
            r_bout  <= w_bo;
            r_state <= DONE;
`ifdef SUB_FLAGS_EN
            r_zero  <= (w_diff_next == '0);
            r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_next[WIDTH-1] != r_a[WIDTH-1]);
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_busy  = (r_state == RUN);
  assign o_done  = (r_state == DONE);
  assign o_diff  = r_diff;
  assign o_bout  = r_bout;
`ifdef SUB_FLAGS_EN
  assign o_zero  = r_zero;
  assign o_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (WIDTH=16); flag checks follow SUB_FLAGS_EN.
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_bin;
  logic         o_ready;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_diff;
  logic         o_bout;
`ifdef SUB_FLAGS_EN
  logic         o_zero;
  logic         o_ovf;
`endif

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_bin   (i_bin),
    .o_ready (o_ready),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_diff  (o_diff),
    .o_bout  (o_bout)
`ifdef SUB_FLAGS_EN
    ,
    .o_zero  (o_zero),
    .o_ovf   (o_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: plain modular arithmetic plus the overflow rule on the operand/result sign bits.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    e.d  = W'(a - b - W'(bin));
    e.bo = (int'(a) < int'(b) + int'(bin));
    e.z  = (e.d == '0);
    e.v  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    sb_q.push_back(e);
  endtask

  // Monitor: whenever the DUT presents done, pop and compare.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(o_done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("diff", 32'(o_diff), 32'(e.d));
        check("bout", 32'(o_bout), 32'(e.bo));
`ifdef SUB_FLAGS_EN
        check("zero", 32'(o_zero), 32'(e.z));
        check("ovf",  32'(o_ovf),  32'(e.v));
`endif
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_ready) return;
    end
    timeout("wait_ready");
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit chk_lat);
    int edges;
    bit got;
    wait_ready();
    i_a = a; i_b = b; i_bin = bin; i_start = 1'b1;
    push_exp(a, b, bin);
    edges = 0;
    got   = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) i_start = 1'b0;
      if (o_done) got = 1'b1;
    end
    if (!got) timeout("run_op_done");
    else if (chk_lat) check("latency", 32'(edges), 32'(W/4 + 1));
  endtask

  initial begin
    int k;
    bit seen;
    rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0; i_bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_done",  32'(o_done),  32'd0);
    check("rst_diff",  32'(o_diff),  32'd0);
    check("rst_bout",  32'(o_bout),  32'd0);
`ifdef SUB_FLAGS_EN
    check("rst_zero",  32'(o_zero),  32'd0);
    check("rst_ovf",   32'(o_ovf),   32'd0);
`endif

    // Directed cases, including full-width borrow propagation and bin.
    run_op(16'h1234, 16'h0234, 1'b0, 1'b1);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0003, 1'b1, 1'b0);
    run_op(16'h0003, 16'h0003, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);

    // Start held through RUN/DONE is ignored; the next accept lands in the IDLE cycle after done.
    wait_ready();
    i_a = 16'h00FF; i_b = 16'h0001; i_bin = 1'b0; i_start = 1'b1;
    push_exp(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    @(negedge clk);
    i_a = 16'h1111; i_b = 16'h0011;
    check("busy_in_run", 32'(o_busy), 32'd1);
    seen = 1'b0;
    for (k = 2; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_ready) seen = 1'b1;
    end
    if (!seen) timeout("held_start_ready");
    else begin
      check("held_accept_cycle", 32'(k - 1), 32'd6);
      push_exp(16'h1111, 16'h0011, 1'b0);
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      check("held_accepted", 32'(o_busy), 32'd1);
    end

    // Reset during the 3rd RUN cycle aborts with no done.
    wait_ready();
    i_a = 16'h4321; i_b = 16'h1111; i_bin = 1'b1; i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_busy",  32'(o_busy),  32'd0);
    check("abort_done",  32'(o_done),  32'd0);
    check("abort_diff",  32'(o_diff),  32'd0);
    check("abort_bout",  32'(o_bout),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_op(16'hABCD, 16'h0123, 1'b1, 1'b1);

    // Randomized operands and borrow-in.
    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
